abc_seq_ctrl: RTL and testbench

Two-requester controller that owns the a→b→c phase handshake on the shared sequence resource. It arbitrates round-robin between two requesters and drives the one-hot phase strobes a, b, c for a programmable number of iterations. Between b and c it waits for the resource acknowledge x, bounded by a timeout. It reports completion on e, timeout on d and busy on y, and sits between the requesting agents and the sequence resource/checker.

---
 rtl/abc_seq_pkg.sv | 9 +
 rtl/rr_arb2.sv | 16 +
 rtl/abc_seq_ctrl.sv | 102 ++++++++++
 tb/tb_abc_seq_ctrl.sv | 124 ++++++++++++
 4 files changed

// File: rtl/abc_seq_pkg.sv
// abc_seq_pkg: shared state encoding and phase one-hot codes for the a/b/c sequence controller
package abc_seq_pkg;
   typedef enum logic [2:0] {IDLE, PH_A, PH_B, WAIT_X, PH_C, DONE, ERR} state_e;
   // {c, b, a} phase strobe patterns
   localparam logic [2:0] PHASE_NONE = 3'b000;
   localparam logic [2:0] PHASE_A    = 3'b001;
   localparam logic [2:0] PHASE_B    = 3'b010;
   localparam logic [2:0] PHASE_C    = 3'b100;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-input round-robin arbiter
//   req_i        : request levels
//   last_owner_i : requester served last; the other one wins a tie
//   en_i         : arbitration enable, no grant when low
//   gnt_nxt_o    : one-hot grant candidate
//   owner_nxt_o  : index of the winning requester
module rr_arb2 (
   input  logic [1:0] req_i,
   input  logic       last_owner_i,
   input  logic       en_i,
   output logic [1:0] gnt_nxt_o,
   output logic       owner_nxt_o
);
   assign owner_nxt_o = (req_i == 2'b11) ? ~last_owner_i : req_i[1];
   assign gnt_nxt_o   = (en_i && |req_i) ? (owner_nxt_o ? 2'b10 : 2'b01) : 2'b00;
endmodule

// File: rtl/abc_seq_ctrl.sv
// abc_seq_ctrl: two-requester controller driving the a->b->c phase handshake
//   clk, rst_n : clock, asynchronous active-low reset
//   req_i      : request level per requester
//   rep_cnt_i  : iterations minus one, sampled at grant
//   x_i        : resource acknowledge, only looked at while waiting after b
//   gnt_o      : one-hot grant for the whole transaction
//   owner_o    : granted requester index, valid while busy
//   a_o/b_o/c_o: one-hot phase strobes
//   d_o        : timeout pulse, e_o: done pulse, y_o: busy
module abc_seq_ctrl
   import abc_seq_pkg::*;
#(
   parameter int MAX_WAIT = 8,
   parameter int REP_W    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req_i,
   input  logic [REP_W-1:0] rep_cnt_i,
   input  logic             x_i,
   output logic [1:0]       gnt_o,
   output logic             owner_o,
   output logic             a_o,
   output logic             b_o,
   output logic             c_o,
   output logic             d_o,
   output logic             e_o,
   output logic             y_o
);
   localparam int WCW = $clog2(MAX_WAIT + 1);
   state_e           state_q, state_d;
   logic             owner_q, owner_d;
   logic             last_owner_q, last_owner_d;
   logic [WCW-1:0]   wcnt_q, wcnt_d;
   logic [REP_W-1:0] rem_q, rem_d;
   logic [1:0]       gnt_nxt;
   logic             owner_nxt;
   logic [2:0]       phase;
   rr_arb2 u_arb (
      .req_i        (req_i),
      .last_owner_i (last_owner_q),
      .en_i         (state_q == IDLE),
      .gnt_nxt_o    (gnt_nxt),
      .owner_nxt_o  (owner_nxt)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;
         wcnt_q       <= '0;
         rem_q        <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         wcnt_q       <= wcnt_d;
         rem_q        <= rem_d;
      end
   end
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      wcnt_d       = wcnt_q;
      rem_d        = rem_q;
      case (state_q)
         IDLE: if (|gnt_nxt) begin
            state_d = PH_A;
            owner_d = owner_nxt;
            rem_d   = rep_cnt_i;
         end
         PH_A: state_d = PH_B;
         PH_B: begin
            state_d = WAIT_X;
            wcnt_d  = '0;
         end
         // acknowledge takes priority over a timeout in the same cycle
         WAIT_X: if (x_i) state_d = PH_C;
            else if (wcnt_q == WCW'(MAX_WAIT - 1)) state_d = ERR;
            else wcnt_d = wcnt_q + WCW'(1);
         PH_C: if (rem_q != '0) begin
            rem_d   = rem_q - REP_W'(1);
            state_d = PH_A;
         end else state_d = DONE;
         DONE, ERR: begin
            last_owner_d = owner_q;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   assign phase = (state_q == PH_A) ? PHASE_A :
                  (state_q == PH_B) ? PHASE_B :
                  (state_q == PH_C) ? PHASE_C : PHASE_NONE;
   assign {c_o, b_o, a_o} = phase;
   assign y_o     = (state_q != IDLE);
   assign d_o     = (state_q == ERR);
   assign e_o     = (state_q == DONE);
   assign owner_o = owner_q;
   assign gnt_o   = y_o ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
endmodule

// File: tb/tb_abc_seq_ctrl.sv
// tb_abc_seq_ctrl: randomized self-checking bench for abc_seq_ctrl against a transaction-level trace model
module tb_abc_seq_ctrl;
   localparam int MAX_WAIT = 8;
   localparam int REP_W    = 4;
   localparam byte P_I = 0, P_A = 1, P_B = 2, P_W = 3, P_X = 4, P_C = 5, P_E = 6, P_D = 7;
   logic             clk = 1'b0;
   logic             rst_n;
   logic [1:0]       req_i;
   logic [REP_W-1:0] rep_cnt_i;
   logic             x_i;
   logic [1:0]       gnt_o;
   logic             owner_o, a_o, b_o, c_o, d_o, e_o, y_o;
   int               n_chk = 0;
   int               n_err = 0;
   int               ntx = 0;
   logic             last_own;
   byte              tr[$];
   abc_seq_ctrl #(.MAX_WAIT(MAX_WAIT), .REP_W(REP_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_i     (req_i),
      .rep_cnt_i (rep_cnt_i),
      .x_i       (x_i),
      .gnt_o     (gnt_o),
      .owner_o   (owner_o),
      .a_o       (a_o),
      .b_o       (b_o),
      .c_o       (c_o),
      .d_o       (d_o),
      .e_o       (e_o),
      .y_o       (y_o)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%b exp=%b", tag, got, exp);
      end
   endtask
   // {gnt[1:0], owner (while busy), a, b, c, d, e, y}
   function automatic logic [8:0] got_vec();
      return {gnt_o, owner_o & y_o, a_o, b_o, c_o, d_o, e_o, y_o};
   endfunction
   function automatic logic [8:0] exp_vec(input byte p, input logic own);
      logic y;
      y = (p != P_I);
      return {y & own, y & ~own, y & own, p == P_A, p == P_B, p == P_C, p == P_D, p == P_E, y};
   endfunction
   // mode: 0 ack immediately, 1 random ack delay (may time out), 2 timeout, 3 ack on last wait cycle
   task automatic run_txn(input logic [1:0] r, input int rep, input int mode);
      logic own;
      int   k;
      bit   to;
      own = (r == 2'b11) ? ~last_own : r[1];
      tr.delete();
      to = 0;
      for (int i = 0; i <= rep && !to; i++) begin
         tr.push_back(P_A);
         tr.push_back(P_B);
         k = (mode == 0) ? 0 : (mode == 2) ? MAX_WAIT : (mode == 3) ? MAX_WAIT - 1 :
             int'($urandom_range(0, MAX_WAIT + 3));
         if (k >= MAX_WAIT) begin
            repeat (MAX_WAIT) tr.push_back(P_W);
            tr.push_back(P_D);
            to = 1;
         end else begin
            repeat (k) tr.push_back(P_W);
            tr.push_back(P_X);
            tr.push_back(P_C);
         end
      end
      if (!to) tr.push_back(P_E);
      tr.push_back(P_I);
      last_own  = own;
      req_i     = r;
      rep_cnt_i = REP_W'(rep);
      x_i       = 1'($urandom_range(0, 1));
      foreach (tr[j]) begin
         @(negedge clk);
         chk($sformatf("txn%0d_cyc%0d", ntx, j), got_vec(), exp_vec(tr[j], own));
         x_i       = (tr[j] == P_X) ? 1'b1 : (tr[j] == P_W) ? 1'b0 : 1'($urandom_range(0, 1));
         req_i     = (tr[j] == P_I) ? 2'b00 : 2'($urandom_range(0, 3));
         rep_cnt_i = REP_W'($urandom);
      end
      ntx++;
   endtask
   initial begin
      rst_n = 1'b0;
      req_i = 2'b00;
      rep_cnt_i = '0;
      x_i = 1'b0;
      last_own = 1'b1;
      #1;
      chk("reset_state", got_vec(), 9'b0);
      chk("reset_owner", {8'b0, owner_o}, 9'b0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) run_txn(2'b11, 0, 0);
      run_txn(2'b01, 0, 0);
      run_txn(2'b10, 2, 0);
      run_txn(2'b01, 0, 2);
      run_txn(2'b10, 1, 3);
      run_txn(2'b01, 15, 0);
      for (int t = 0; t < 30; t++)
         run_txn(2'($urandom_range(1, 3)), int'($urandom_range(0, 3)), 1);
      req_i = 2'b01;
      rep_cnt_i = '0;
      x_i = 1'b0;
      repeat (3) @(negedge clk);
      req_i = 2'b00;
      chk("pre_reset_wait", got_vec(), exp_vec(P_W, 1'b0));
      #1 rst_n = 1'b0;
      #1;
      chk("reset_mid", got_vec(), 9'b0);
      chk("reset_mid_owner", {8'b0, owner_o}, 9'b0);
      @(negedge clk);
      rst_n = 1'b1;
      last_own = 1'b1;
      run_txn(2'b11, 0, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
